// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM encoding, error codes and digit/accumulator limits.
package stopwatch_pkg;

    localparam int unsigned ACC_W   = 14;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned ERR_W   = 2;

    localparam logic [DIGIT_W-1:0] MAX_BCD_DIGIT = 4'd9;
    localparam logic [DIGIT_W-1:0] MAX_SEC_TENS  = 4'd5;

    localparam logic [ERR_W-1:0] ERR_OK    = 2'b00;
    localparam logic [ERR_W-1:0] ERR_DIGIT = 2'b01;
    localparam logic [ERR_W-1:0] ERR_OVF   = 2'b10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MU   = 3'd1,
        ST   = 3'd2,
        SU   = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/bcd_mac_step.sv
// One Horner step: acc*10 + d or acc*6 + d, built from shifts and adds only.
module bcd_mac_step
    import stopwatch_pkg::*;
(
    input  logic [ACC_W-1:0]   acc,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               sel_ten,
    output logic [ACC_W-1:0]   result_c
);

    logic [ACC_W-1:0] scaled;

    always_comb begin
        scaled = (acc << 1);
        if (sel_ten) begin
            scaled = (acc << 3) + (acc << 1);
        end else begin
            scaled = (acc << 2) + (acc << 1);
        end
        result_c = scaled + ACC_W'(digit);
    end

endmodule

// File: rtl/bcd_to_seconds.sv
// Packs MM:SS BCD digits into a binary seconds count via a multi-cycle mixed-radix Horner walk.
module bcd_to_seconds
    import stopwatch_pkg::*;
#(
    parameter int unsigned SEC_W   = 12,
    parameter int unsigned MAX_SEC = (1 << SEC_W) - 1
) (
    input  logic               src_clk,
    input  logic               src_rst,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [3:0]         sec_u,
    input  logic [3:0]         sec_t,
    input  logic [3:0]         min_u,
    input  logic [3:0]         min_t,
    output logic               out_valid,
    output logic [1:0]         err,
    output logic [SEC_W-1:0]   seconds
);

    localparam logic [ACC_W-1:0] MAX_ACC = ACC_W'(MAX_SEC);

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [3:0]         min_u_q;
    logic [3:0]         sec_t_q;
    logic [3:0]         sec_u_q;
    logic [3:0]         step_digit;
    logic               step_ten;
    logic [ACC_W-1:0]   step_result;
    logic               digits_bad_c;

    // The shared MAC picks its digit and radix from the current step.
    always_comb begin
        step_digit = min_u_q;
        step_ten   = 1'b1;
        case (state)
            ST: begin
                step_digit = sec_t_q;
                step_ten   = 1'b0;
            end
            SU:      step_digit = sec_u_q;
            default: step_digit = min_u_q;
        endcase
    end

    assign digits_bad_c = (min_t > MAX_BCD_DIGIT) || (min_u > MAX_BCD_DIGIT) ||
                          (sec_t > MAX_SEC_TENS)  || (sec_u > MAX_BCD_DIGIT);

    bcd_mac_step u_mac (
        .acc      (acc),
        .digit    (step_digit),
        .sel_ten  (step_ten),
        .result_c (step_result)
    );

    always_ff @(posedge src_clk) begin
        if (src_rst) begin
            state      <= IDLE;
            load_ready <= 1'b1;
            out_valid  <= 1'b0;
            err        <= ERR_OK;
            seconds    <= '0;
            acc        <= '0;
            min_u_q    <= '0;
            sec_t_q    <= '0;
            sec_u_q    <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        min_u_q    <= min_u;
                        sec_t_q    <= sec_t;
                        sec_u_q    <= sec_u;
                        load_ready <= 1'b0;
                        if (digits_bad_c) begin
                            err       <= ERR_DIGIT;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            acc   <= ACC_W'(min_t);
                            state <= MU;
                        end
                    end
                end
                MU: begin
                    acc   <= step_result;
                    state <= ST;
                end
                ST: begin
                    acc   <= step_result;
                    state <= SU;
                end
                SU: begin
                    acc       <= step_result;
                    out_valid <= 1'b1;
                    state     <= DONE;
                    // Range check on the full accumulator width, before truncation.
                    if (step_result > MAX_ACC) begin
                        err <= ERR_OVF;
                    end else begin
                        err     <= ERR_OK;
                        seconds <= SEC_W'(step_result);
                    end
                end
                DONE: begin
                    load_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    load_ready <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_seconds.sv
// Scoreboard bench for bcd_to_seconds: expected results queued at accept, checked on out_valid.
module tb_bcd_to_seconds;

    logic        src_clk = 1'b0;
    logic        src_rst;
    logic        load_valid;
    logic        load_ready;
    logic [3:0]  sec_u, sec_t, min_u, min_t;
    logic        out_valid;
    logic [1:0]  err;
    logic [11:0] seconds;

    typedef struct {
        logic [1:0]  err;
        logic [11:0] sec;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] model_sec;
    int          cyc;
    int          checks;
    int          errors;

    bcd_to_seconds dut (
        .src_clk    (src_clk),
        .src_rst    (src_rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .sec_u      (sec_u),
        .sec_t      (sec_t),
        .min_u      (min_u),
        .min_t      (min_t),
        .out_valid  (out_valid),
        .err        (err),
        .seconds    (seconds)
    );

    always #5 src_clk = ~src_clk;

    always @(posedge src_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Reference result from positional weights; accept edge is the cycle number it lands on.
    task automatic push_expected(input logic [3:0] mt, input logic [3:0] mu,
                                 input logic [3:0] st, input logic [3:0] su,
                                 input int accept);
        exp_t e;
        int   val;
        val = 600 * int'(mt) + 60 * int'(mu) + 10 * int'(st) + int'(su);
        if (mt > 9 || mu > 9 || st > 5 || su > 9) begin
            e.err = 2'b01;
            e.cyc = accept;
        end else if (val > 4095) begin
            e.err = 2'b10;
            e.cyc = accept + 3;
        end else begin
            e.err     = 2'b00;
            e.cyc     = accept + 3;
            model_sec = 12'(val);
        end
        e.sec = model_sec;
        exp_q.push_back(e);
    endtask

    always @(negedge src_clk) begin
        if (!src_rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("err", 32'(err), 32'(e.err));
                check("seconds", 32'(seconds), 32'(e.sec));
                check("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!load_ready && n < 50) begin
            @(negedge src_clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'(load_ready), 32'd1);
    endtask

    task automatic start(input logic [3:0] mt, input logic [3:0] mu,
                         input logic [3:0] st, input logic [3:0] su);
        @(negedge src_clk);
        wait_ready();
        min_t = mt; min_u = mu; sec_t = st; sec_u = su;
        load_valid = 1'b1;
        push_expected(mt, mu, st, su, cyc + 1);
        @(negedge src_clk);
        load_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !load_ready) && n < 100) begin
            @(negedge src_clk);
            n++;
        end
        if (n >= 100) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic conv(input logic [3:0] mt, input logic [3:0] mu,
                        input logic [3:0] st, input logic [3:0] su);
        start(mt, mu, st, su);
        drain();
    endtask

    initial begin
        cyc = 0; checks = 0; errors = 0; model_sec = '0;
        src_rst = 1'b1; load_valid = 1'b1;
        min_t = 4'd1; min_u = 4'd2; sec_t = 4'd3; sec_u = 4'd4;

        // Reset with a request pending.
        repeat (2) @(negedge src_clk);
        check("rst_ready", 32'(load_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_seconds", 32'(seconds), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        load_valid = 1'b0;
        src_rst = 1'b0;
        @(negedge src_clk);
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // Normal and range cases.
        conv(4'd1, 4'd2, 4'd3, 4'd4);
        conv(4'd0, 4'd0, 4'd0, 4'd0);
        conv(4'd0, 4'd0, 4'd5, 4'd9);
        conv(4'd6, 4'd8, 4'd1, 4'd5);
        conv(4'd6, 4'd8, 4'd1, 4'd6);
        conv(4'd9, 4'd9, 4'd5, 4'd9);
        conv(4'd0, 4'd1, 4'd6, 4'd0);
        conv(4'd0, 4'hA, 4'd0, 4'd0);
        conv(4'd0, 4'd0, 4'd0, 4'hF);

        // Busy-time changes and requests are ignored.
        start(4'd1, 4'd2, 4'd3, 4'd4);
        min_t = 4'd9; min_u = 4'd9; sec_t = 4'd5; sec_u = 4'd9;
        check("busy_ready_mu", 32'(load_ready), 32'd0);
        load_valid = 1'b1;
        @(negedge src_clk);
        check("busy_ready_st", 32'(load_ready), 32'd0);
        load_valid = 1'b0;
        drain();

        // Back-to-back with load_valid held high.
        @(negedge src_clk);
        wait_ready();
        min_t = 4'd0; min_u = 4'd0; sec_t = 4'd5; sec_u = 4'd9;
        load_valid = 1'b1;
        for (int k = 0; k < 3; k++) push_expected(4'd0, 4'd0, 4'd5, 4'd9, cyc + 1 + 5 * k);
        repeat (13) @(negedge src_clk);
        load_valid = 1'b0;
        drain();

        conv(4'd1, 4'd0, 4'd0, 4'd0);

        // Reset while in ST: no result, outputs back to reset values.
        @(negedge src_clk);
        wait_ready();
        min_t = 4'd2; min_u = 4'd0; sec_t = 4'd0; sec_u = 4'd0;
        load_valid = 1'b1;
        @(negedge src_clk);
        load_valid = 1'b0;
        @(negedge src_clk);
        src_rst = 1'b1;
        @(negedge src_clk);
        src_rst = 1'b0;
        model_sec = '0;
        @(negedge src_clk);
        check("midrst_ready", 32'(load_ready), 32'd1);
        check("midrst_seconds", 32'(seconds), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        repeat (6) @(negedge src_clk);

        conv(4'd0, 4'd0, 4'd0, 4'd7);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
